// File: rtl/sound_pkg.sv
// -----------------------------------------------------------------------------
// sound_pkg
// Shared definitions for the poly_sound_gen voice synthesiser:
//   - default parameter values
//   - waveform codes carried on cmd_wave
//   - sequencer state encoding
//   - noise LFSR seed, tap mask and single-step helper
// -----------------------------------------------------------------------------
package sound_pkg;

  localparam int DEF_NUM_VOICES = 4;
  localparam int DEF_PHASE_W    = 16;
  localparam int DEF_DUR_W      = 8;
  localparam int DEF_TICK_DIV   = 4608;

  // Fibonacci LFSR x^16+x^14+x^13+x^11, shifting right. Those polynomial terms
  // land on register bits 0, 2, 3 and 5, hence the tap mask.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [2:0] {
    WAVE_OFF      = 3'd0,
    WAVE_SQUARE   = 3'd1,
    WAVE_TRIANGLE = 3'd2,
    WAVE_SAW      = 3'd3,
    WAVE_NOISE    = 3'd4
  } wave_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  // One LFSR step: the feedback bit enters at the top.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

  // Codes 5..7 are not real waveforms and behave exactly like "off".
  function automatic logic wave_is_on(input logic [2:0] w);
    wave_is_on = (w != 3'd0) && (w <= 3'd4);
  endfunction

endpackage

// File: rtl/poly_sound_gen_if.sv
// -----------------------------------------------------------------------------
// poly_sound_gen_if
// Command channel into poly_sound_gen.
//   cmd_valid/cmd_ready : handshake, a command is taken when both are high
//   cmd_voice           : target voice index
//   cmd_wave            : waveform code (see sound_pkg::wave_e)
//   cmd_vol             : volume, 3 is loudest
//   cmd_step            : phase increment per sample tick
//   cmd_dur             : note length in ticks, 0 = sustain forever
//   stop_all            : silences every voice, wins over a command
// master = command source, slave = poly_sound_gen.
// -----------------------------------------------------------------------------
interface poly_sound_gen_if
  import sound_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int PHASE_W    = DEF_PHASE_W,
  parameter int DUR_W      = DEF_DUR_W
);
  localparam int VW = $clog2(NUM_VOICES);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [VW-1:0]      cmd_voice;
  logic [2:0]         cmd_wave;
  logic [1:0]         cmd_vol;
  logic [PHASE_W-1:0] cmd_step;
  logic [DUR_W-1:0]   cmd_dur;
  logic               stop_all;

  modport master (
    output cmd_valid, cmd_voice, cmd_wave, cmd_vol, cmd_step, cmd_dur, stop_all,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_voice, cmd_wave, cmd_vol, cmd_step, cmd_dur, stop_all,
    output cmd_ready
  );
endinterface

// File: rtl/sound_voice_wave.sv
// -----------------------------------------------------------------------------
// sound_voice_wave
// Combinational waveform + volume datapath for one voice slot.
//   wave    : waveform code
//   vol     : volume 0..3
//   phase   : top 16 bits of the voice phase accumulator
//   lfsr    : current noise LFSR value
//   contrib : signed 16-bit contribution (waveform >>> (4 - vol))
// -----------------------------------------------------------------------------
module sound_voice_wave
  import sound_pkg::*;
(
  input  logic [2:0]         wave,
  input  logic [1:0]         vol,
  input  logic [15:0]        phase,
  input  logic [15:0]        lfsr,
  output logic signed [15:0] contrib
);

  wave_e       wave_sel;
  logic [15:0] raw;
  logic [2:0]  shift;

  // Waveform lookup followed by volume scaling.
  always_comb begin
    wave_sel = wave_e'(wave);
    raw      = 16'h0000;
    case (wave_sel)
      WAVE_SQUARE:   raw = phase[15] ? 16'h8000 : 16'h7FFF;
      // Fold the second half-cycle back down, then move to two's complement.
      WAVE_TRIANGLE: raw = {(phase[15] ? ~phase[14:0] : phase[14:0]), 1'b0} ^ 16'h8000;
      WAVE_SAW:      raw = phase ^ 16'h8000;
      WAVE_NOISE:    raw = lfsr;
      default:       raw = 16'h0000;
    endcase
    // vol 3 halves the full-scale wave, vol 0 divides it by 16.
    shift   = 3'd4 - {1'b0, vol};
    contrib = $signed(raw) >>> shift;
  end

endmodule

// File: rtl/poly_sound_gen.sv
// -----------------------------------------------------------------------------
// poly_sound_gen
// Time-multiplexed polyphonic tone generator. Every TICK_DIV clocks one sample
// is built by visiting each voice in turn (one clock per voice), summing the
// contributions, saturating to 16 bits and driving a first-order sigma-delta
// modulator.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   cmd           : command channel (poly_sound_gen_if.slave)
//   voice_active  : per-voice active flags
//   sample        : signed 16-bit mix, updated once per tick
//   sample_valid  : one-cycle strobe with each new sample
//   pwm           : sigma-delta bitstream
// -----------------------------------------------------------------------------
module poly_sound_gen
  import sound_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int PHASE_W    = DEF_PHASE_W,
  parameter int DUR_W      = DEF_DUR_W,
  parameter int TICK_DIV   = DEF_TICK_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  poly_sound_gen_if.slave       cmd,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic [15:0]           sample,
  output logic                  sample_valid,
  output logic                  pwm
);

  localparam int VW    = $clog2(NUM_VOICES);
  localparam int CW    = $clog2(TICK_DIV);
  localparam int ACC_W = 16 + $clog2(NUM_VOICES) + 1;

  // Sequencer
  logic [CW-1:0]    cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [VW-1:0]    slot_q, slot_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ready_q, ready_d;
  logic             tick;

  // Voice storage
  logic [2:0]         wave_q  [NUM_VOICES];
  logic [2:0]         wave_d  [NUM_VOICES];
  logic [1:0]         vol_q   [NUM_VOICES];
  logic [1:0]         vol_d   [NUM_VOICES];
  logic [PHASE_W-1:0] step_q  [NUM_VOICES];
  logic [PHASE_W-1:0] step_d  [NUM_VOICES];
  logic [DUR_W-1:0]   dur_q   [NUM_VOICES];
  logic [DUR_W-1:0]   dur_d   [NUM_VOICES];
  logic [PHASE_W-1:0] phase_q [NUM_VOICES];
  logic [PHASE_W-1:0] phase_d [NUM_VOICES];
  logic [15:0]        lfsr_q  [NUM_VOICES];
  logic [15:0]        lfsr_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0] active_q, active_d, active_pre;

  // Output stage
  logic [15:0] sample_q, sample_d;
  logic        sample_valid_q, sample_valid_d;
  logic [16:0] sd_acc_q, sd_acc_d;

  logic              cmd_accept;
  logic              voice_ok;
  logic signed [15:0] contrib;
  logic [ACC_W-1:0]  contrib_ext;
  logic [ACC_W-16:0] acc_top;
  logic [15:0]       sat_sum;

  assign tick         = (cnt_q == CW'(TICK_DIV - 1));
  assign cmd_accept   = cmd.cmd_valid && ready_q;
  assign voice_ok     = ({1'b0, cmd.cmd_voice} < (VW + 1)'(NUM_VOICES));

  assign cmd.cmd_ready = ready_q;
  assign voice_active  = active_q;
  assign sample        = sample_q;
  assign sample_valid  = sample_valid_q;
  assign pwm           = sd_acc_q[16];

  sound_voice_wave u_wave (
    .wave    (wave_q[slot_q]),
    .vol     (vol_q[slot_q]),
    .phase   (phase_q[slot_q][PHASE_W-1 -: 16]),
    .lfsr    (lfsr_q[slot_q]),
    .contrib (contrib)
  );

  // Slot contribution, sign-extended; silent voices add nothing.
  always_comb begin
    if (active_q[slot_q]) begin
      contrib_ext = {{(ACC_W - 16){contrib[15]}}, contrib};
    end else begin
      contrib_ext = {ACC_W{1'b0}};
    end
  end

  // Saturate the wide sum: it fits in 16 bits only when the bits above
  // bit 14 are all copies of the sign.
  always_comb begin
    acc_top = acc_q[ACC_W-1:15];
    if ((&acc_top) || (~|acc_top)) begin
      sat_sum = acc_q[15:0];
    end else if (acc_q[ACC_W-1]) begin
      sat_sum = 16'h8000;
    end else begin
      sat_sum = 16'h7FFF;
    end
  end

  // Tick divider, sample sequencer FSM and output-stage next state.
  always_comb begin
    cnt_d          = tick ? {CW{1'b0}} : cnt_q + CW'(1);
    state_d        = state_q;
    slot_d         = slot_q;
    acc_d          = acc_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_ACCUM;
          slot_d  = {VW{1'b0}};
          acc_d   = {ACC_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        acc_d = acc_q + contrib_ext;
        if (slot_q == VW'(NUM_VOICES - 1)) begin
          state_d = ST_OUT;
          slot_d  = {VW{1'b0}};
        end else begin
          slot_d = slot_q + VW'(1);
        end
      end
      ST_OUT: begin
        state_d        = ST_IDLE;
        sample_d       = sat_sum;
        sample_valid_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        slot_d  = {VW{1'b0}};
      end
    endcase
    // Ready is registered from the next state so it equals
    // (state == IDLE && !tick) in every cycle without a combinational path.
    ready_d  = (state_d == ST_IDLE) && (cnt_d != CW'(TICK_DIV - 1));
    sd_acc_d = {1'b0, sd_acc_q[15:0]} + {1'b0, sample_q ^ 16'h8000};
  end

  // Voice updates: advance the voice owning the current slot during ACCUM,
  // otherwise load an accepted command. Commands are only taken in IDLE, so
  // the two never collide.
  always_comb begin
    wave_d     = wave_q;
    vol_d      = vol_q;
    step_d     = step_q;
    dur_d      = dur_q;
    phase_d    = phase_q;
    lfsr_d     = lfsr_q;
    active_pre = active_q;
    if ((state_q == ST_ACCUM) && active_q[slot_q]) begin
      phase_d[slot_q] = phase_q[slot_q] + step_q[slot_q];
      lfsr_d[slot_q]  = lfsr_next(lfsr_q[slot_q]);
      if (dur_q[slot_q] != DUR_W'(0)) begin
        dur_d[slot_q] = dur_q[slot_q] - DUR_W'(1);
        // Last tick of the note: it still contributed above, now it ends.
        active_pre[slot_q] = (dur_q[slot_q] != DUR_W'(1));
      end else begin
        dur_d[slot_q] = dur_q[slot_q];
      end
    end else if (cmd_accept && voice_ok) begin
      wave_d[cmd.cmd_voice]     = cmd.cmd_wave;
      vol_d[cmd.cmd_voice]      = cmd.cmd_vol;
      step_d[cmd.cmd_voice]     = cmd.cmd_step;
      dur_d[cmd.cmd_voice]      = cmd.cmd_dur;
      phase_d[cmd.cmd_voice]    = {PHASE_W{1'b0}};
      lfsr_d[cmd.cmd_voice]     = LFSR_SEED;
      active_pre[cmd.cmd_voice] = wave_is_on(cmd.cmd_wave);
    end else begin
      active_pre = active_q;
    end
    active_d = cmd.stop_all ? {NUM_VOICES{1'b0}} : active_pre;
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= {CW{1'b0}};
      state_q        <= ST_IDLE;
      slot_q         <= {VW{1'b0}};
      acc_q          <= {ACC_W{1'b0}};
      ready_q        <= 1'b1;
      sample_q       <= 16'h0000;
      sample_valid_q <= 1'b0;
      sd_acc_q       <= 17'h00000;
    end else begin
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      slot_q         <= slot_d;
      acc_q          <= acc_d;
      ready_q        <= ready_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      sd_acc_q       <= sd_acc_d;
    end
  end

  // Voice register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        wave_q[v]  <= 3'd0;
        vol_q[v]   <= 2'd0;
        step_q[v]  <= {PHASE_W{1'b0}};
        dur_q[v]   <= {DUR_W{1'b0}};
        phase_q[v] <= {PHASE_W{1'b0}};
        lfsr_q[v]  <= LFSR_SEED;
      end
      active_q <= {NUM_VOICES{1'b0}};
    end else begin
      wave_q   <= wave_d;
      vol_q    <= vol_d;
      step_q   <= step_d;
      dur_q    <= dur_d;
      phase_q  <= phase_d;
      lfsr_q   <= lfsr_d;
      active_q <= active_d;
    end
  end

endmodule

// File: tb/tb_poly_sound_gen.sv
// -----------------------------------------------------------------------------
// tb_poly_sound_gen
// Self-checking bench for poly_sound_gen (NUM_VOICES=4, TICK_DIV=16). A
// behavioural model computes each sample atomically at the tick from
// per-voice arrays; directed scenarios plus a randomized command stream.
// -----------------------------------------------------------------------------
module tb_poly_sound_gen;

  localparam int NV = 4;
  localparam int PW = 16;
  localparam int DW = 8;
  localparam int TD = 16;

  logic          clk;
  logic          rst;
  logic [NV-1:0] voice_active;
  logic [15:0]   sample;
  logic          sample_valid;
  logic          pwm;

  poly_sound_gen_if #(.NUM_VOICES(NV), .PHASE_W(PW), .DUR_W(DW)) cmd_if ();

  poly_sound_gen #(.NUM_VOICES(NV), .PHASE_W(PW), .DUR_W(DW), .TICK_DIV(TD)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cmd_if.slave),
    .voice_active (voice_active),
    .sample       (sample),
    .sample_valid (sample_valid),
    .pwm          (pwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_cnt, m_cd, m_sd, m_sample, m_pending;
  bit m_valid;
  int v_wave[NV], v_vol[NV], v_step[NV], v_dur[NV], v_phase[NV], v_lfsr[NV];
  bit v_on[NV];
  logic        last_ready;
  logic [15:0] got_q[$];

  function automatic void model_reset();
    m_cnt = 0; m_cd = 0; m_sd = 0; m_sample = 0; m_pending = 0; m_valid = 0;
    for (int v = 0; v < NV; v++) begin
      v_wave[v] = 0; v_vol[v] = 0; v_step[v] = 0; v_dur[v] = 0;
      v_phase[v] = 0; v_lfsr[v] = 'hACE1; v_on[v] = 0;
    end
  endfunction

  function automatic int wave_value(int w, int p, int l);
    case (w)
      1:       return (p < 32768) ? 32767 : -32768;
      2:       return (p < 32768) ? (2 * p - 32768) : (2 * (65535 - p) - 32768);
      3:       return p - 32768;
      4:       return (l >= 32768) ? (l - 65536) : l;
      default: return 0;
    endcase
  endfunction

  function automatic int lfsr_step(int l);
    int fb;
    fb = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
    return (fb << 15) | (l >> 1);
  endfunction

  function automatic void model_tick();
    int sum;
    sum = 0;
    for (int v = 0; v < NV; v++) begin
      if (v_on[v]) begin
        sum += wave_value(v_wave[v], v_phase[v], v_lfsr[v]) >>> (4 - v_vol[v]);
        v_phase[v] = (v_phase[v] + v_step[v]) & 'hFFFF;
        v_lfsr[v]  = lfsr_step(v_lfsr[v]);
        if (v_dur[v] != 0) begin
          v_dur[v]--;
          if (v_dur[v] == 0) v_on[v] = 0;
        end
      end
    end
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    m_pending = sum & 'hFFFF;
  endfunction

  function automatic logic [NV-1:0] model_active();
    logic [NV-1:0] a;
    for (int v = 0; v < NV; v++) a[v] = v_on[v];
    return a;
  endfunction

  function automatic bit model_ready();
    return (m_cd == 0) && (m_cnt != TD - 1);
  endfunction

  // One clock: check ready, apply the edge to the model, check outputs.
  task automatic clk_cycle();
    bit exp_ready, tick;
    int vi, w;
    exp_ready  = model_ready();
    last_ready = cmd_if.cmd_ready;
    check_val("cmd_ready", {31'd0, cmd_if.cmd_ready}, {31'd0, exp_ready});
    @(posedge clk);
    tick    = (m_cnt == TD - 1);
    m_sd    = (m_sd & 'hFFFF) + (m_sample ^ 'h8000);
    m_valid = 0;
    if (m_cd > 0) begin
      m_cd--;
      if (m_cd == 0) begin
        m_sample = m_pending;
        m_valid  = 1;
      end
    end
    if (cmd_if.cmd_valid && exp_ready) begin
      vi = int'(cmd_if.cmd_voice);
      w  = int'(cmd_if.cmd_wave);
      v_wave[vi] = w; v_vol[vi] = int'(cmd_if.cmd_vol);
      v_step[vi] = int'(cmd_if.cmd_step); v_dur[vi] = int'(cmd_if.cmd_dur);
      v_phase[vi] = 0; v_lfsr[vi] = 'hACE1;
      v_on[vi] = (w >= 1) && (w <= 4);
    end
    if (cmd_if.stop_all) begin
      for (int v = 0; v < NV; v++) v_on[v] = 0;
    end
    if (tick) begin
      model_tick();
      m_cd = 5;
    end
    m_cnt = tick ? 0 : m_cnt + 1;
    @(negedge clk);
    check_val("sample_valid", {31'd0, sample_valid}, {31'd0, m_valid});
    check_val("sample", {16'd0, sample}, m_sample);
    check_val("pwm", {31'd0, pwm}, (m_sd >> 16) & 1);
    if (m_cd == 0) check_val("voice_active", {28'd0, voice_active}, {28'd0, model_active()});
    if (sample_valid) got_q.push_back(sample);
  endtask

  task automatic clear_inputs();
    cmd_if.cmd_valid = 1'b0; cmd_if.stop_all = 1'b0;
    cmd_if.cmd_voice = 2'd0; cmd_if.cmd_wave = 3'd0; cmd_if.cmd_vol = 2'd0;
    cmd_if.cmd_step = 16'h0000; cmd_if.cmd_dur = 8'h00;
  endtask

  task automatic reset_dut();
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_sample", {16'd0, sample}, 32'd0);
    check_val("rst_valid", {31'd0, sample_valid}, 32'd0);
    check_val("rst_pwm", {31'd0, pwm}, 32'd0);
    check_val("rst_active", {28'd0, voice_active}, 32'd0);
    check_val("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic send_cmd(input int v, input int w, input int vol, input int step,
                          input int dur, input bit stop);
    bit done;
    done = 0;
    cmd_if.cmd_voice = v[1:0]; cmd_if.cmd_wave = w[2:0]; cmd_if.cmd_vol = vol[1:0];
    cmd_if.cmd_step = step[15:0]; cmd_if.cmd_dur = dur[7:0];
    cmd_if.cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      cmd_if.stop_all = stop && model_ready();
      clk_cycle();
      done = last_ready;
    end
    if (!done) check_val("cmd_accept_timeout", 32'd0, 32'd1);
    clear_inputs();
  endtask

  task automatic wait_samples(input int k);
    for (int i = 0; i < 40 * k && got_q.size() < k; i++) clk_cycle();
    if (got_q.size() < k) check_val("sample_timeout", got_q.size(), k);
  endtask

  task automatic run_to_tick();
    for (int i = 0; i < 40 && m_cnt != TD - 1; i++) clk_cycle();
    check_val("reach_tick", m_cnt, TD - 1);
  endtask

  logic [15:0] sq_exp[4];
  logic [15:0] saw_exp[4];
  int low_cycles, nonzero;
  bit acc_done;

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();

    // Idle: zero samples, 50% pwm.
    reset_dut();
    for (int i = 0; i < 40; i++) clk_cycle();

    // Square voice cycling through four quarter-periods.
    sq_exp = '{16'h3FFF, 16'h3FFF, 16'hC000, 16'hC000};
    reset_dut();
    got_q.delete();
    send_cmd(0, 1, 3, 'h4000, 0, 0);
    wait_samples(8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) check_val("square_seq", {16'd0, got_q[i]}, {16'd0, sq_exp[i % 4]});

    // Four full-scale squares saturate.
    reset_dut();
    for (int v = 0; v < NV; v++) send_cmd(v, 1, 3, 0, 0, 0);
    got_q.delete();
    wait_samples(2);
    for (int i = 0; i < 2 && i < got_q.size(); i++) check_val("saturate", {16'd0, got_q[i]}, 32'h7FFF);

    // Sawtooth with a three-tick duration.
    saw_exp = '{16'hC000, 16'hC800, 16'hD000, 16'h0000};
    reset_dut();
    got_q.delete();
    send_cmd(1, 3, 3, 'h1000, 3, 0);
    wait_samples(4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check_val("saw_dur", {16'd0, got_q[i]}, {16'd0, saw_exp[i]});
    check_val("saw_inactive", {31'd0, voice_active[1]}, 32'd0);

    // Command raised on the tick cycle waits out the busy window.
    reset_dut();
    run_to_tick();
    cmd_if.cmd_voice = 2'd2; cmd_if.cmd_wave = 3'd2; cmd_if.cmd_vol = 2'd2;
    cmd_if.cmd_step = 16'h0800; cmd_if.cmd_dur = 8'h00; cmd_if.cmd_valid = 1'b1;
    low_cycles = 0; acc_done = 0;
    for (int i = 0; i < 20 && !acc_done; i++) begin
      clk_cycle();
      if (last_ready) acc_done = 1;
      else low_cycles++;
    end
    clear_inputs();
    check_val("ready_low_cycles", low_cycles, 6);
    check_val("tick_cmd_active", {31'd0, voice_active[2]}, 32'd1);
    send_cmd(3, 1, 3, 'h0100, 0, 1);
    check_val("stop_wins", {28'd0, voice_active}, 32'd0);

    // Reset in the second ACCUM cycle aborts the sample.
    reset_dut();
    got_q.delete();
    send_cmd(0, 1, 3, 'h4000, 0, 0);
    wait_samples(2);
    run_to_tick();
    clk_cycle();
    clk_cycle();
    #2 rst = 1'b1;
    #1;
    check_val("abort_sample", {16'd0, sample}, 32'd0);
    check_val("abort_valid", {31'd0, sample_valid}, 32'd0);
    check_val("abort_pwm", {31'd0, pwm}, 32'd0);
    check_val("abort_active", {28'd0, voice_active}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    got_q.delete();
    for (int i = 0; i < 20; i++) clk_cycle();
    nonzero = 0;
    foreach (got_q[i]) if (got_q[i] != 16'h0000) nonzero++;
    check_val("abort_no_sample", nonzero, 0);

    // Randomized command stream, including commands while busy.
    reset_dut();
    for (int i = 0; i < 600; i++) begin
      cmd_if.cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_if.cmd_voice = 2'($urandom_range(0, NV - 1));
      cmd_if.cmd_wave  = 3'($urandom_range(0, 7));
      cmd_if.cmd_vol   = 2'($urandom_range(0, 3));
      cmd_if.cmd_step  = 16'($urandom);
      cmd_if.cmd_dur   = 8'($urandom_range(0, 6));
      cmd_if.stop_all  = model_ready() && ($urandom_range(0, 49) == 0);
      clk_cycle();
    end
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
